// File: rtl/multi_flex_counter_pkg.sv
// Shared defaults and types for the multi-channel flex counter.
package multi_flex_counter_pkg;

   localparam int unsigned DefaultNumCntBits = 4;
   localparam int unsigned DefaultNumChannels = 2;

   typedef enum logic {
      CNT_DOWN = 1'b0,
      CNT_UP   = 1'b1
   } cnt_dir_t;

endpackage

// File: rtl/flex_counter_channel.sv
// One up/down rollover counter channel with clear, load, terminal flag and wrap pulse.
module flex_counter_channel
   import multi_flex_counter_pkg::*;
#(
   parameter int unsigned NUM_CNT_BITS = DefaultNumCntBits
) (
   input  logic                    clk_i,
   input  logic                    n_rst_i,
   input  logic                    clear_i,
   input  logic                    enable_i,
   input  logic                    count_up_i,
   input  logic                    load_i,
   input  logic [NUM_CNT_BITS-1:0] load_val_i,
   input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
   output logic [NUM_CNT_BITS-1:0] count_o,
   output logic                    flag_o,
   output logic                    wrap_pulse_o,
   output logic                    wrap_event_o
);

   localparam logic [NUM_CNT_BITS-1:0] CntOne = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

   logic [NUM_CNT_BITS-1:0] count_q, count_d;
   logic                    flag_q, flag_d;
   logic                    wrap_q, wrap_d;
   logic [NUM_CNT_BITS-1:0] term_val;
   logic                    wrap_event;
   cnt_dir_t                dir;

   assign dir      = cnt_dir_t'(count_up_i);
   assign term_val = (dir == CNT_UP) ? rollover_val_i : CntOne;

   always_comb begin
      count_d    = count_q;
      wrap_event = 1'b0;
      if (clear_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = load_val_i;
      end else if (enable_i) begin
         if (dir == CNT_UP) begin
            // >= so that lowering R below the count still wraps next cycle
            if (count_q >= rollover_val_i) begin
               count_d    = CntOne;
               wrap_event = 1'b1;
            end else begin
               count_d = count_q + CntOne;
            end
         end else begin
            if (count_q <= CntOne) begin
               count_d    = rollover_val_i;
               wrap_event = 1'b1;
            end else begin
               count_d = count_q - CntOne;
            end
         end
      end
      flag_d = !clear_i && (count_d == term_val);
      wrap_d = wrap_event;
   end

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         count_q <= '0;
         flag_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         flag_q  <= flag_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count_o      = count_q;
   assign flag_o       = flag_q;
   assign wrap_pulse_o = wrap_q;
   assign wrap_event_o = wrap_event;

endmodule

// File: rtl/multi_flex_counter.sv
// Bank of independent flex counters; MULTI_FLEX_COUNTER_CASCADE_EN chains them as a prescaler.
module multi_flex_counter
   import multi_flex_counter_pkg::*;
#(
   parameter int unsigned NUM_CNT_BITS = DefaultNumCntBits,
   parameter int unsigned NUM_CHANNELS = DefaultNumChannels
) (
   input  logic                                      clk_i,
   input  logic                                      n_rst_i,
   input  logic [NUM_CHANNELS-1:0]                   clear_i,
   input  logic [NUM_CHANNELS-1:0]                   count_enable_i,
   input  logic [NUM_CHANNELS-1:0]                   count_up_i,
   input  logic [NUM_CHANNELS-1:0]                   load_i,
   input  logic [NUM_CHANNELS-1:0][NUM_CNT_BITS-1:0] load_val_i,
   input  logic [NUM_CHANNELS-1:0][NUM_CNT_BITS-1:0] rollover_val_i,
   output logic [NUM_CHANNELS-1:0][NUM_CNT_BITS-1:0] count_out_o,
   output logic [NUM_CHANNELS-1:0]                   rollover_flag_o,
   output logic [NUM_CHANNELS-1:0]                   wrap_pulse_o
);

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      logic chan_en;
      logic chan_wrap;

`ifdef MULTI_FLEX_COUNTER_CASCADE_EN
      // Per-block nets keep the enable chain free of self-referencing vectors
      if (i == 0) begin : g_head
         assign chan_en = count_enable_i[i];
      end else begin : g_link
         assign chan_en = count_enable_i[i] & g_ch[i-1].chan_wrap;
      end
`else
      logic unused_wrap;
      assign chan_en     = count_enable_i[i];
      assign unused_wrap = chan_wrap;
`endif

      flex_counter_channel #(
         .NUM_CNT_BITS(NUM_CNT_BITS)
      ) u_channel (
         .clk_i         (clk_i),
         .n_rst_i       (n_rst_i),
         .clear_i       (clear_i[i]),
         .enable_i      (chan_en),
         .count_up_i    (count_up_i[i]),
         .load_i        (load_i[i]),
         .load_val_i    (load_val_i[i]),
         .rollover_val_i(rollover_val_i[i]),
         .count_o       (count_out_o[i]),
         .flag_o        (rollover_flag_o[i]),
         .wrap_pulse_o  (wrap_pulse_o[i]),
         .wrap_event_o  (chan_wrap)
      );
   end

endmodule

// File: tb/tb_multi_flex_counter.sv
// Directed self-checking bench for multi_flex_counter (W=4, two channels).
module tb_multi_flex_counter;

   logic             clk;
   logic             n_rst;
   logic [1:0]       clear;
   logic [1:0]       count_enable;
   logic [1:0]       count_up;
   logic [1:0]       load;
   logic [1:0][3:0]  load_val;
   logic [1:0][3:0]  rollover_val;
   logic [1:0][3:0]  count_out;
   logic [1:0]       rollover_flag;
   logic [1:0]       wrap_pulse;

   int pass_cnt = 0;
   int total_cnt = 0;

   multi_flex_counter #(
      .NUM_CNT_BITS(4),
      .NUM_CHANNELS(2)
   ) dut (
      .clk_i         (clk),
      .n_rst_i       (n_rst),
      .clear_i       (clear),
      .count_enable_i(count_enable),
      .count_up_i    (count_up),
      .load_i        (load),
      .load_val_i    (load_val),
      .rollover_val_i(rollover_val),
      .count_out_o   (count_out),
      .rollover_flag_o(rollover_flag),
      .wrap_pulse_o  (wrap_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      #2;
      total_cnt++;
      if (count_out !== 8'h00) $display("FAIL reset_count got %h want 00", count_out);
      else pass_cnt++;
      total_cnt++;
      if (rollover_flag !== 2'b00 || wrap_pulse !== 2'b00)
         $display("FAIL reset_flags got flag=%b wrap=%b want 00/00", rollover_flag, wrap_pulse);
      else pass_cnt++;
      n_rst = 1'b1;
      rollover_val[0] = 4'd5;
      count_up[0] = 1'b1;
      count_enable[0] = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      count_enable[0] = 1'b0;
      total_cnt++;
      if (count_out[0] !== 4'd3) $display("FAIL pre_reset_count got %0d want 3", count_out[0]);
      else pass_cnt++;
      #3;
      n_rst = 1'b0;
      #1;
      total_cnt++;
      if (count_out[0] !== 4'd0 || rollover_flag[0] !== 1'b0 || wrap_pulse[0] !== 1'b0)
         $display("FAIL async_reset got cnt=%0d flag=%b wrap=%b want 0/0/0",
                  count_out[0], rollover_flag[0], wrap_pulse[0]);
      else pass_cnt++;
      #1;
      n_rst = 1'b1;
   endtask

   task automatic test_up_wrap();
      int exp_c [6];
      exp_c = '{1, 2, 3, 4, 5, 1};
      rollover_val[0] = 4'd5;
      count_up[0] = 1'b1;
      count_enable[0] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         total_cnt++;
         if (count_out[0] !== 4'(exp_c[k]) || rollover_flag[0] !== (exp_c[k] == 5) ||
             wrap_pulse[0] !== (k == 5))
            $display("FAIL up_wrap[%0d] got cnt=%0d flag=%b wrap=%b want %0d/%b/%b", k,
                     count_out[0], rollover_flag[0], wrap_pulse[0], exp_c[k], exp_c[k] == 5,
                     k == 5);
         else pass_cnt++;
      end
      count_enable[0] = 1'b0;
   endtask

   task automatic test_down_wrap();
      int exp_c [5];
      exp_c = '{1, 3, 2, 1, 3};
      count_up[0] = 1'b0;
      rollover_val[0] = 4'd3;
      load_val[0] = 4'd2;
      load[0] = 1'b1;
      tick();
      load[0] = 1'b0;
      total_cnt++;
      if (count_out[0] !== 4'd2 || rollover_flag[0] !== 1'b0)
         $display("FAIL down_load got cnt=%0d flag=%b want 2/0", count_out[0], rollover_flag[0]);
      else pass_cnt++;
      count_enable[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         total_cnt++;
         if (count_out[0] !== 4'(exp_c[k]) || rollover_flag[0] !== (exp_c[k] == 1) ||
             wrap_pulse[0] !== (exp_c[k] == 3))
            $display("FAIL down_wrap[%0d] got cnt=%0d flag=%b wrap=%b want %0d/%b/%b", k,
                     count_out[0], rollover_flag[0], wrap_pulse[0], exp_c[k], exp_c[k] == 1,
                     exp_c[k] == 3);
         else pass_cnt++;
      end
      count_enable[0] = 1'b0;
   endtask

   task automatic test_priority();
      // Count is 3 in down mode with a wrap pulse pending from the last test
      clear[0] = 1'b1;
      load[0] = 1'b1;
      count_enable[0] = 1'b1;
      load_val[0] = 4'd7;
      tick();
      total_cnt++;
      if (count_out[0] !== 4'd0 || rollover_flag[0] !== 1'b0 || wrap_pulse[0] !== 1'b0)
         $display("FAIL prio_clear got cnt=%0d flag=%b wrap=%b want 0/0/0",
                  count_out[0], rollover_flag[0], wrap_pulse[0]);
      else pass_cnt++;
      clear[0] = 1'b0;
      tick();
      total_cnt++;
      if (count_out[0] !== 4'd7 || wrap_pulse[0] !== 1'b0)
         $display("FAIL prio_load got cnt=%0d wrap=%b want 7/0", count_out[0], wrap_pulse[0]);
      else pass_cnt++;
      load_val[0] = 4'd1;
      tick();
      total_cnt++;
      if (count_out[0] !== 4'd1 || rollover_flag[0] !== 1'b1)
         $display("FAIL load_flag got cnt=%0d flag=%b want 1/1", count_out[0], rollover_flag[0]);
      else pass_cnt++;
      load[0] = 1'b0;
      count_enable[0] = 1'b0;
   endtask

   task automatic test_edge_values();
      clear[0] = 1'b1;
      tick();
      clear[0] = 1'b0;
      count_up[0] = 1'b1;
      rollover_val[0] = 4'd0;
      count_enable[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         total_cnt++;
         if (count_out[0] !== 4'd1 || rollover_flag[0] !== 1'b0)
            $display("FAIL r0_up[%0d] got cnt=%0d flag=%b want 1/0", k, count_out[0],
                     rollover_flag[0]);
         else pass_cnt++;
      end
      count_enable[0] = 1'b0;
      load[0] = 1'b1;
      load_val[0] = 4'd9;
      tick();
      load[0] = 1'b0;
      rollover_val[0] = 4'd4;
      count_enable[0] = 1'b1;
      tick();
      total_cnt++;
      if (count_out[0] !== 4'd1 || wrap_pulse[0] !== 1'b1 || rollover_flag[0] !== 1'b0)
         $display("FAIL r_lowered got cnt=%0d wrap=%b flag=%b want 1/1/0", count_out[0],
                  wrap_pulse[0], rollover_flag[0]);
      else pass_cnt++;
      count_enable[0] = 1'b0;
      tick();
      total_cnt++;
      if (count_out[0] !== 4'd1 || wrap_pulse[0] !== 1'b0)
         $display("FAIL wrap_one_cycle got cnt=%0d wrap=%b want 1/0", count_out[0],
                  wrap_pulse[0]);
      else pass_cnt++;
      load[0] = 1'b1;
      load_val[0] = 4'd15;
      rollover_val[0] = 4'd15;
      tick();
      load[0] = 1'b0;
      total_cnt++;
      if (count_out[0] !== 4'd15 || rollover_flag[0] !== 1'b1)
         $display("FAIL max_load got cnt=%0d flag=%b want 15/1", count_out[0], rollover_flag[0]);
      else pass_cnt++;
      count_enable[0] = 1'b1;
      tick();
      total_cnt++;
      if (count_out[0] !== 4'd1 || wrap_pulse[0] !== 1'b1)
         $display("FAIL max_wrap got cnt=%0d wrap=%b want 1/1", count_out[0], wrap_pulse[0]);
      else pass_cnt++;
      count_up[0] = 1'b0;
      rollover_val[0] = 4'd0;
      tick();
      total_cnt++;
      if (count_out[0] !== 4'd0 || rollover_flag[0] !== 1'b0 || wrap_pulse[0] !== 1'b1)
         $display("FAIL r0_down got cnt=%0d flag=%b wrap=%b want 0/0/1", count_out[0],
                  rollover_flag[0], wrap_pulse[0]);
      else pass_cnt++;
      count_enable[0] = 1'b0;
   endtask

   task automatic test_cascade();
      int exp0 [10];
      int exp1 [10];
      logic exp_w1;
      exp0 = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 1};
`ifdef MULTI_FLEX_COUNTER_CASCADE_EN
      exp1 = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 1};
      exp_w1 = 1'b1;
`else
      exp1 = '{1, 2, 1, 2, 1, 2, 1, 2, 1, 2};
      exp_w1 = 1'b0;
`endif
      clear = 2'b11;
      tick();
      clear = 2'b00;
      count_up = 2'b11;
      rollover_val[0] = 4'd3;
      rollover_val[1] = 4'd2;
      count_enable = 2'b11;
      for (int k = 0; k < 10; k++) begin
         tick();
         total_cnt++;
         if (count_out[0] !== 4'(exp0[k]) || count_out[1] !== 4'(exp1[k]))
            $display("FAIL cascade[%0d] got ch0=%0d ch1=%0d want %0d/%0d", k, count_out[0],
                     count_out[1], exp0[k], exp1[k]);
         else pass_cnt++;
      end
      total_cnt++;
      if (wrap_pulse[1] !== exp_w1)
         $display("FAIL cascade_wrap1 got %b want %b", wrap_pulse[1], exp_w1);
      else pass_cnt++;
      count_enable = 2'b00;
   endtask

   initial begin
      n_rst = 1'b0;
      clear = '0;
      count_enable = '0;
      count_up = '0;
      load = '0;
      load_val = '0;
      rollover_val = '0;
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_priority();
      test_edge_values();
      test_cascade();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
